udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Shares the single UDP transmit engine between the two OV5640 camera channels. Each channel's line buffer requests the engine with a packet length. The arbiter grants channels round-robin and launches the UDP core with length and channel ID. It routes the core's data-request strobe and data bus to the granted channel, then enforces an inter-packet gap. It sits between the two camera packetizers and the UDP/RGMII transmit path in the Ethernet TX clock domain.

## Interface
Parameters:
- IPG_CYCLES, 16, idle cycles inserted after each packet (0 allowed)
- MAX_LEN, 1472, largest legal payload length in bytes
- TIMEOUT_CYCLES, 65535, BUSY watchdog limit (used only with the watchdog macro)

Ports:
- sys_clk  in  1  sole clock; all logic on the rising edge
- sys_rst  in  1  synchronous, active-high reset
- src_req  in  2  per channel: packet ready; level, held until src_ack
- src_len0 / src_len1  in  16  payload bytes for channel 0 / 1; stable while src_req is high
- src_data0 / src_data1  in  32  FIFO read data for channel 0 / 1
- src_ack  out  2  one-cycle pulse: request accepted (launched or dropped)
- src_rd_en  out  2  FIFO read strobe; only the granted bit can be high
- src_done  out  2  one-cycle pulse: packet finished (or aborted)
- tx_start_en  out  1  one-cycle launch pulse to the UDP core
- tx_byte_num  out  16  registered payload length; held from START until the next launch
- tx_ch_id  out  1  registered channel ID for the UDP header
- tx_req  in  1  data request from the UDP core
- tx_data  out  32  data to the UDP core
- tx_done  in  1  one-cycle pulse from the UDP core: frame sent
- busy  out  1  high in START, BUSY and GAP
- err_len  out  1  one-cycle pulse: illegal length dropped
- err_timeout  out  1  one-cycle pulse: watchdog abort

## Operation
- States: IDLE, START, BUSY, GAP.
- **IDLE**
  - If any src_req bit is high, choose a channel:
    - Only one channel requesting: that channel.
    - Both requesting: the channel not equal to last_grant.
  - Register the grant (grant, tx_byte_num, tx_ch_id) and update last_grant.
  - Legal length (1..MAX_LEN): go to START.
  - Illegal length (0 or >MAX_LEN): pulse src_ack[ch] and err_len in the next cycle, stay in IDLE. The illegal request still updates last_grant.
- **START** (one cycle)
  - tx_start_en=1 and src_ack[grant]=1, then go to BUSY.
- **BUSY**
  - src_rd_en[grant] = tx_req (combinational). The other channel's src_rd_en bit is 0.
  - tx_data = grant ? src_data1 : src_data0 (combinational).
  - On tx_done: go to GAP with gap counter = IPG_CYCLES, and pulse src_done[grant] in the cycle after tx_done.
  - If IPG_CYCLES==0, go straight to IDLE instead of GAP.
- **GAP**
  - Decrement the gap counter each cycle; go to IDLE when it reaches 1.
  - Requests are not sampled during GAP.
- tx_req outside BUSY is ignored: src_rd_en=0, tx_data=0.
- tx_done outside BUSY is ignored.
- A src_req drop before src_ack is a protocol violation; behaviour is undefined and not checked.
- Reset during any state: next cycle is IDLE with every output 0, last_grant=1 (so channel 0 wins the first tie), and counters cleared. An in-flight packet is abandoned with no src_done.

## Timing
- Reset values: every output is 0, including tx_byte_num and tx_ch_id.
- Request latency: src_req sampled high in IDLE at cycle N gives tx_start_en and src_ack at N+1. BUSY begins at N+2.
- src_rd_en and tx_data follow tx_req / grant with zero added latency.
- src_done at cycle D+1 for tx_done at cycle D. The earliest next tx_start_en is D+IPG_CYCLES+2.
- Back-to-back service alternates channels when both are continuously requesting.
- A request and tx_done in the same cycle: tx_done is handled first; the request waits for IDLE.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in BUSY and is cleared on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without tx_done, the arbiter aborts: err_timeout and src_done[grant] pulse next cycle, then it enters GAP.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and err_timeout is tied to 0.
  - BUSY waits for tx_done indefinitely.

## Test plan
- Reset, then src_req=2'b01, src_len0=1024:
  - tx_start_en and src_ack=01 one cycle after the request.
  - tx_byte_num=1024, tx_ch_id=0.
  - tx_done gives src_done=01 next cycle; the next start is no earlier than IPG_CYCLES+2 cycles after tx_done.
- Both channels held requesting (lengths 256 / 512) for 4 packets:
  - tx_ch_id sequence 0,1,0,1.
  - tx_byte_num 256,512,256,512.
- In BUSY, grant=1, tx_req toggling:
  - src_rd_en=10 exactly when tx_req=1.
  - tx_data equals src_data1.
  - src_rd_en[0] never asserts.
- src_len0=0, then src_len0=1500 with MAX_LEN=1472:
  - Each gives an src_ack and err_len pulse, with no tx_start_en.
  - The arbiter stays IDLE.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100 and tx_done withheld:
  - err_timeout and src_done pulse 101 cycles after BUSY entry.
  - The arbiter then passes through GAP and accepts a new request.
- sys_rst asserted mid-BUSY:
  - All outputs are 0 the next cycle and no src_done pulses.
  - With both channels requesting after release, channel 0 is granted first.

Source files
------------

// File: rtl/udp_tx_arbiter_if.sv
// Signal bundle between the two camera packetizers, the TX arbiter and the UDP core.
// master = arbiter side, slave = packetizers plus UDP core.
interface udp_tx_arbiter_if;
    logic [1:0]  src_req;
    logic [15:0] src_len0;
    logic [15:0] src_len1;
    logic [31:0] src_data0;
    logic [31:0] src_data1;
    logic [1:0]  src_ack;
    logic [1:0]  src_rd_en;
    logic [1:0]  src_done;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_ch_id;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        busy;
    logic        err_len;
    logic        err_timeout;

    modport master (
        input  src_req, src_len0, src_len1, src_data0, src_data1, tx_req, tx_done,
        output src_ack, src_rd_en, src_done, tx_start_en, tx_byte_num, tx_ch_id,
               tx_data, busy, err_len, err_timeout
    );

    modport slave (
        output src_req, src_len0, src_len1, src_data0, src_data1, tx_req, tx_done,
        input  src_ack, src_rd_en, src_done, tx_start_en, tx_byte_num, tx_ch_id,
               tx_data, busy, err_len, err_timeout
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX engine between two camera channels.
// Optional BUSY watchdog: define ARB_TIMEOUT_EN.
module udp_tx_arbiter #(
    parameter int IPG_CYCLES     = 16,
    parameter int MAX_LEN        = 1472,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    udp_tx_arbiter_if.master bus,
    output logic [1:0]       dbg_state
);
    // Handshakes: src_req is a level held until the one-cycle src_ack (launch or drop);
    // src_rd_en/tx_data follow tx_req in the same cycle; tx_done and src_done are single-cycle pulses.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);
    localparam logic [15:0] IPG_L     = 16'(IPG_CYCLES);

    state_t      state, state_next;
    logic        last_grant;
    logic        grant;
    logic [15:0] byte_num_q;
    logic [15:0] gap_cnt;
    logic [1:0]  ack_drop_q;
    logic [1:0]  done_q;
    logic        err_len_q;
    logic        err_to_q;
    logic        pick;
    logic [15:0] pick_len;
    logic        len_ok;
    logic        accept;
    logic        timeout_hit;
    logic        pkt_end;

    // Requests are ignored in the cycle a drop is acknowledged, so the dropped level is not re-sampled.
    always_comb begin
        pick = 1'b0;
        if (bus.src_req == 2'b10)
            pick = 1'b1;
        else if (bus.src_req == 2'b11)
            pick = ~last_grant;
        pick_len = pick ? bus.src_len1 : bus.src_len0;
        len_ok   = (pick_len != 16'd0) && (pick_len <= MAX_LEN_L);
        accept   = (state == ST_IDLE) && (|bus.src_req) && (ack_drop_q == 2'b00);
        pkt_end  = (state == ST_BUSY) && (bus.tx_done || timeout_hit);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            to_cnt <= '0;
        else if (state == ST_START)
            to_cnt <= '0;
        else if (state == ST_BUSY)
            to_cnt <= to_cnt + 16'd1;
    end

    assign timeout_hit = (to_cnt == TIMEOUT_L) && !bus.tx_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            err_to_q <= 1'b0;
        else
            err_to_q <= (state == ST_BUSY) && timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign err_to_q    = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && len_ok) state_next = ST_START;
            ST_START: state_next = ST_BUSY;
            ST_BUSY:  if (pkt_end) state_next = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt <= 16'd1) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_start_en = (state == ST_START);
        bus.busy        = (state != ST_IDLE);
        bus.src_ack     = ack_drop_q;
        bus.src_rd_en   = 2'b00;
        bus.tx_data     = 32'd0;
        if (state == ST_START)
            bus.src_ack[grant] = 1'b1;
        if (state == ST_BUSY) begin
            bus.src_rd_en[grant] = bus.tx_req;
            bus.tx_data          = grant ? bus.src_data1 : bus.src_data0;
        end
        bus.src_done    = done_q;
        bus.err_len     = err_len_q;
        bus.err_timeout = err_to_q;
        bus.tx_byte_num = byte_num_q;
        bus.tx_ch_id    = grant;
    end

    assign dbg_state = state;

    // last_grant starts at 1 so channel 0 wins the first tie; illegal requests still rotate it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            byte_num_q <= '0;
            gap_cnt    <= '0;
            ack_drop_q <= '0;
            done_q     <= '0;
            err_len_q  <= 1'b0;
        end else begin
            ack_drop_q <= 2'b00;
            done_q     <= 2'b00;
            err_len_q  <= 1'b0;
            if (accept) begin
                last_grant <= pick;
                if (len_ok) begin
                    grant      <= pick;
                    byte_num_q <= pick_len;
                end else begin
                    ack_drop_q[pick] <= 1'b1;
                    err_len_q        <= 1'b1;
                end
            end
            if (pkt_end) begin
                done_q[grant] <= 1'b1;
                gap_cnt       <= IPG_L;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed scenarios plus a randomized run against a round-robin model.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
  localparam int IPG  = 5;
  localparam int MAXL = 1472;
  localparam int TMO  = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] dbg_state;

  udp_tx_arbiter_if bus();

  udp_tx_arbiter #(
    .IPG_CYCLES(IPG), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / global time limit
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.src_req = 2'b00; bus.src_len0 = 16'd0; bus.src_len1 = 16'd0;
    bus.src_data0 = 32'd0; bus.src_data1 = 32'd0; bus.tx_req = 1'b0; bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      tick();
      n++;
      if (bus.tx_start_en || bus.err_len) seen = 1'b1;
    end
  endtask

  task automatic finish_pkt();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    repeat (IPG + 1) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.tx_req = 1'b1; bus.src_data0 = 32'hDEADBEEF;
    sys_rst = 1'b1;
    tick();
    tick();
    total++; if ({bus.tx_start_en, bus.src_ack, bus.src_rd_en, bus.src_done, bus.busy, bus.err_len, bus.err_timeout} !== 10'd0) begin bad++; $display("FAIL reset_ctl got=%b want=0", {bus.tx_start_en, bus.src_ack, bus.src_rd_en, bus.src_done, bus.busy, bus.err_len, bus.err_timeout}); end
    total++; if ({bus.tx_byte_num, bus.tx_ch_id} !== 17'd0) begin bad++; $display("FAIL reset_len_id got=%0h want=0", {bus.tx_byte_num, bus.tx_ch_id}); end
    total++; if (bus.tx_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h want=0", bus.tx_data); end
    sys_rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.src_len0 = 16'd1024; bus.src_req = 2'b01;
    tick();
    total++; if (bus.tx_start_en !== 1'b1) begin bad++; $display("FAIL single_start got=%0b want=1", bus.tx_start_en); end
    total++; if (bus.src_ack !== 2'b01) begin bad++; $display("FAIL single_ack got=%b want=01", bus.src_ack); end
    total++; if (bus.tx_byte_num !== 16'd1024) begin bad++; $display("FAIL single_len got=%0d want=1024", bus.tx_byte_num); end
    total++; if (bus.tx_ch_id !== 1'b0) begin bad++; $display("FAIL single_ch got=%0d want=0", bus.tx_ch_id); end
    bus.src_req = 2'b00;
    repeat (4) tick();
    total++; if (bus.busy !== 1'b1 || bus.src_done !== 2'b00) begin bad++; $display("FAIL single_busy got=%b%b want=100", bus.busy, bus.src_done); end
    // tx_done together with a new request: tx_done wins, request waits for IDLE
    bus.tx_done = 1'b1; bus.src_len0 = 16'd100; bus.src_req = 2'b01;
    tick();
    bus.tx_done = 1'b0;
    total++; if (bus.src_done !== 2'b01) begin bad++; $display("FAIL single_done got=%b want=01", bus.src_done); end
    n = 1;
    while (!bus.tx_start_en && n < 100) begin
      tick();
      n++;
    end
    total++; if (n !== IPG + 2) begin bad++; $display("FAIL single_gap got=%0d want=%0d", n, IPG + 2); end
    bus.src_req = 2'b00;
    tick();
    finish_pkt();
  endtask

  task automatic test_round_robin();
    int n;
    bit seen;
    bit model_last;
    bit exp_ch;
    do_reset();
    model_last = 1'b1;
    bus.src_len0 = 16'd256; bus.src_len1 = 16'd512; bus.src_req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_start(50, n, seen);
      exp_ch = ~model_last;
      model_last = exp_ch;
      total++; if (!seen || bus.tx_start_en !== 1'b1) begin bad++; $display("FAIL rr_start pkt=%0d got=%0b want=1", p, bus.tx_start_en); end
      total++; if (bus.tx_ch_id !== exp_ch) begin bad++; $display("FAIL rr_ch pkt=%0d got=%0d want=%0d", p, bus.tx_ch_id, exp_ch); end
      total++; if (bus.tx_byte_num !== (exp_ch ? 16'd512 : 16'd256)) begin bad++; $display("FAIL rr_len pkt=%0d got=%0d want=%0d", p, bus.tx_byte_num, exp_ch ? 512 : 256); end
      if (p == 3) bus.src_req = 2'b00;
      tick();
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    repeat (IPG + 1) tick();
  endtask

  task automatic test_rd_en();
    do_reset();
    bus.src_len1 = 16'd64; bus.src_req = 2'b10;
    tick();
    total++; if (bus.src_ack !== 2'b10 || bus.tx_ch_id !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b/%0d want=10/1", bus.src_ack, bus.tx_ch_id); end
    bus.src_req = 2'b00;
    tick();
    bus.src_data0 = 32'hAAAA5555;
    for (int i = 0; i < 8; i++) begin
      bus.tx_req = 1'($urandom_range(0, 1));
      bus.src_data1 = $urandom;
      #1;
      total++; if (bus.src_rd_en !== {bus.tx_req, 1'b0}) begin bad++; $display("FAIL rd_en i=%0d got=%b want=%b", i, bus.src_rd_en, {bus.tx_req, 1'b0}); end
      total++; if (bus.tx_data !== bus.src_data1) begin bad++; $display("FAIL rd_data i=%0d got=%0h want=%0h", i, bus.tx_data, bus.src_data1); end
      tick();
    end
    bus.tx_req = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    bus.tx_req = 1'b1;
    #1;
    total++; if (bus.src_rd_en !== 2'b00 || bus.tx_data !== 32'd0) begin bad++; $display("FAIL gap_rd got=%b/%0h want=00/0", bus.src_rd_en, bus.tx_data); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++; if (bus.src_done !== 2'b00) begin bad++; $display("FAIL gap_done got=%b want=00", bus.src_done); end
    bus.tx_req = 1'b0;
    repeat (IPG + 2) tick();
  endtask

  task automatic test_illegal();
    logic [15:0] bad_len[2];
    bad_len[0] = 16'd0;
    bad_len[1] = 16'd1500;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.src_len0 = bad_len[k]; bus.src_req = 2'b01;
      tick();
      total++; if ({bus.err_len, bus.src_ack, bus.tx_start_en} !== 4'b1010) begin bad++; $display("FAIL illegal_drop len=%0d got=%b want=1010", bad_len[k], {bus.err_len, bus.src_ack, bus.tx_start_en}); end
      bus.src_req = 2'b00;
      tick();
      total++; if ({bus.busy, bus.err_len, bus.tx_start_en, dbg_state} !== 5'd0) begin bad++; $display("FAIL illegal_idle len=%0d got=%b want=00000", bad_len[k], {bus.busy, bus.err_len, bus.tx_start_en, dbg_state}); end
      tick();
    end
    bus.src_len0 = 16'd1472; bus.src_req = 2'b01;
    tick();
    total++; if (bus.tx_start_en !== 1'b1 || bus.err_len !== 1'b0 || bus.tx_byte_num !== 16'd1472) begin bad++; $display("FAIL max_len got=%0b/%0b/%0d want=1/0/1472", bus.tx_start_en, bus.err_len, bus.tx_byte_num); end
    bus.src_req = 2'b00;
    tick();
    finish_pkt();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit seen;
    do_reset();
    bus.src_len0 = 16'd100; bus.src_req = 2'b01;
    tick();
    bus.src_req = 2'b00;
    tick();
    n = 0;
    while (n < 300 && !bus.err_timeout) begin
      tick();
      n++;
    end
    total++; if (n !== TMO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO + 1); end
    total++; if (bus.src_done !== 2'b01) begin bad++; $display("FAIL timeout_done got=%b want=01", bus.src_done); end
    bus.src_len0 = 16'd200; bus.src_req = 2'b01;
    wait_start(50, n, seen);
    total++; if (!seen || bus.tx_start_en !== 1'b1 || bus.tx_byte_num !== 16'd200) begin bad++; $display("FAIL timeout_restart got=%0b/%0d want=1/200", bus.tx_start_en, bus.tx_byte_num); end
    bus.src_req = 2'b00;
    tick();
    finish_pkt();
  endtask
`else
  task automatic test_no_timeout();
    bit saw;
    do_reset();
    saw = 1'b0;
    bus.src_len0 = 16'd100; bus.src_req = 2'b01;
    tick();
    bus.src_req = 2'b00;
    repeat (TMO + 20) begin
      tick();
      if (bus.err_timeout || bus.src_done != 2'b00 || !bus.busy) saw = 1'b1;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL no_timeout got=%0b want=0", saw); end
    finish_pkt();
  endtask
`endif

  task automatic test_reset_mid_busy();
    int n;
    bit seen;
    bit saw_done;
    do_reset();
    bus.src_len0 = 16'd300; bus.src_req = 2'b01;
    tick();
    bus.src_req = 2'b00;
    tick();
    bus.tx_req = 1'b1; bus.src_data0 = 32'h12345678;
    tick();
    sys_rst = 1'b1;
    tick();
    total++; if ({bus.tx_start_en, bus.src_ack, bus.src_rd_en, bus.src_done, bus.busy, bus.err_len, bus.err_timeout} !== 10'd0) begin bad++; $display("FAIL rst_busy_ctl got=%b want=0", {bus.tx_start_en, bus.src_ack, bus.src_rd_en, bus.src_done, bus.busy, bus.err_len, bus.err_timeout}); end
    total++; if ({bus.tx_byte_num, bus.tx_ch_id, bus.tx_data} !== 49'd0) begin bad++; $display("FAIL rst_busy_data got=%0h want=0", {bus.tx_byte_num, bus.tx_ch_id, bus.tx_data}); end
    sys_rst = 1'b0;
    bus.tx_req = 1'b0;
    bus.src_len0 = 16'd256; bus.src_len1 = 16'd512; bus.src_req = 2'b11;
    n = 0; seen = 1'b0; saw_done = 1'b0;
    while (n < 20 && !seen) begin
      tick();
      n++;
      if (bus.src_done != 2'b00) saw_done = 1'b1;
      if (bus.tx_start_en) seen = 1'b1;
    end
    total++; if (!seen || bus.tx_ch_id !== 1'b0) begin bad++; $display("FAIL rst_first_grant got=%0b/%0d want=1/0", seen, bus.tx_ch_id); end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%0b want=0", saw_done); end
    bus.src_req = 2'b10;
    tick();
    finish_pkt();
    bus.src_req = 2'b00;
    wait_start(20, n, seen);
    tick();
    finish_pkt();
  endtask

  // randomized traffic against a round-robin reference model
  task automatic test_random();
    bit          pend[2];
    logic [15:0] len[2];
    bit          model_last;
    bit          ch;
    bit          legal;
    int          n;
    int          r;
    bit          seen;
    logic [17:0] obs;
    logic [17:0] exp;
    do_reset();
    idle_inputs();
    pend[0] = 1'b0; pend[1] = 1'b0;
    model_last = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && ($urandom_range(0, 1) == 1 || (c == 1 && !pend[0]))) begin
          r = $urandom_range(0, 9);
          if (r == 0) len[c] = 16'd0;
          else if (r == 1) len[c] = 16'($urandom_range(MAXL + 1, 65535));
          else if (r == 2) len[c] = ($urandom_range(0, 1) == 1) ? 16'(MAXL) : 16'd1;
          else len[c] = 16'($urandom_range(1, MAXL));
          pend[c] = 1'b1;
        end
      end
      bus.src_len0 = len[0]; bus.src_len1 = len[1];
      bus.src_req = {pend[1], pend[0]};
      if (pend[0] && pend[1]) ch = ~model_last;
      else ch = pend[1];
      model_last = ch;
      legal = (len[ch] >= 16'd1) && (len[ch] <= 16'(MAXL));
      exp_q.push_back({~legal, ch, legal ? len[ch] : 16'd0});
      wait_start(60, n, seen);
      obs = {bus.err_len, bus.src_ack[1], bus.err_len ? 16'd0 : bus.tx_byte_num};
      exp = exp_q.pop_front();
      total++; if (!seen || obs !== exp) begin bad++; $display("FAIL rand_event it=%0d got=%0h want=%0h", it, obs, exp); end
      total++; if (!$onehot(bus.src_ack) || (bus.tx_start_en && bus.err_len)) begin bad++; $display("FAIL rand_ack it=%0d got=%b/%0b%0b want=onehot", it, bus.src_ack, bus.tx_start_en, bus.err_len); end
      pend[ch] = 1'b0;
      bus.src_req = {pend[1], pend[0]};
      if (legal) begin
        tick();
        repeat ($urandom_range(2, 5)) begin
          bus.tx_req = 1'($urandom_range(0, 1));
          bus.src_data0 = $urandom; bus.src_data1 = $urandom;
          #1;
          total++; if (bus.src_rd_en !== (bus.tx_req ? (ch ? 2'b10 : 2'b01) : 2'b00)) begin bad++; $display("FAIL rand_rd it=%0d got=%b", it, bus.src_rd_en); end
          total++; if (bus.tx_data !== (ch ? bus.src_data1 : bus.src_data0)) begin bad++; $display("FAIL rand_data it=%0d got=%0h", it, bus.tx_data); end
          tick();
        end
        bus.tx_req = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        total++; if (bus.src_done !== (ch ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rand_done it=%0d got=%b want=%0d", it, bus.src_done, ch); end
      end
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_queue got=%0d want=0", exp_q.size()); end
    bus.src_req = 2'b00;
    repeat (IPG + 2) tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_rd_en();
    test_illegal();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_busy();
    test_random();
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
